// File: rtl/dice_pkg.sv
// Shared definitions for the dice-roll engine arbiter: die codes, FSM states, result width.
package dice_pkg;

    localparam int RESULT_W = 32;

    localparam logic [RESULT_W-1:0] DIE_D4        = 0;
    localparam logic [RESULT_W-1:0] DIE_D6        = 1;
    localparam logic [RESULT_W-1:0] DIE_D8        = 2;
    localparam logic [RESULT_W-1:0] DIE_D10       = 3;
    localparam logic [RESULT_W-1:0] DIE_D12       = 4;
    localparam logic [RESULT_W-1:0] DIE_D20       = 5;
    localparam logic [RESULT_W-1:0] DIE_D100      = 6;
    localparam logic [RESULT_W-1:0] DIE_MAX_VALID = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    // Only codes the engine knows how to roll; anything else is answered locally with an error.
    function automatic logic die_code_valid(input logic [RESULT_W-1:0] code);
        case (code)
            DIE_D4, DIE_D6, DIE_D8, DIE_D10, DIE_D12, DIE_D20, DIE_D100: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above ptr, wrapping.
// Holds no state so any shared resource can pair it with its own pointer register.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             any_req
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/dice_roll_arbiter.sv
// Round-robin sequencer sharing one dice-roll instruction engine among NUM_REQ requesters.
// Define DICE_ARB_TIMEOUT_EN to abort a stalled roll after TIMEOUT_CYCLES in WAIT with rsp_err.
module dice_roll_arbiter
    import dice_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DIE_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*DIE_W-1:0] die_sel,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [RESULT_W-1:0]      rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     rng_clk_en,
    output logic                     rng_start,
    output logic [RESULT_W-1:0]      rng_dataa,
    output logic [RESULT_W-1:0]      rng_datab,
    input  logic [RESULT_W-1:0]      rng_result,
    input  logic                     rng_done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("dice_roll_arbiter: NUM_REQ must be in 2..8");
    end
    if (DIE_W < $clog2(DIE_MAX_VALID + 1) || DIE_W > RESULT_W) begin : g_bad_die_w
        $error("dice_roll_arbiter: DIE_W cannot hold every valid die code");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dice_roll_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    owner_q;
    logic [PTR_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0]  grant;
    logic                any_req;
    logic [DIE_W-1:0]    sel_code;
    logic                code_ok;
    logic [RESULT_W-1:0] result_q;
    logic                err_q;
    logic                timeout_hit;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .grant   (grant),
        .any_req (any_req)
    );

    always_comb begin
        grant_idx = '0;
        sel_code  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
                sel_code  = die_sel[i*DIE_W +: DIE_W];
            end
        end
    end

    assign code_ok = die_code_valid(RESULT_W'(sel_code));

`ifdef DICE_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] wait_cnt;

    // Counts cycles spent in WAIT; cleared whenever the FSM is anywhere else.
    always_ff @(posedge clk) begin
        if (reset || state_q != ST_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = code_ok ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: state_d = rng_done ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                if (rng_done || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // All handshake outputs are registered: pulses default low and are raised for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            ack       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            rng_start <= 1'b0;
            rng_dataa <= '0;
        end else begin
            state_q   <= state_d;
            busy      <= (state_d != ST_IDLE);
            ack       <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rng_start <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        ack     <= grant;
                        owner_q <= grant_idx;
                        if (code_ok) begin
                            rng_start <= 1'b1;
                            rng_dataa <= RESULT_W'(sel_code);
                            err_q     <= 1'b0;
                        end else begin
                            err_q    <= 1'b1;
                            result_q <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (rng_done) begin
                        result_q <= rng_result;
                    end
                end
                ST_WAIT: begin
                    if (rng_done) begin
                        result_q <= rng_result;
                    end else if (timeout_hit) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid[owner_q] <= 1'b1;
                    rsp_data           <= result_q;
                    rsp_err            <= err_q;
                    ptr_q              <= (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rng_clk_en = 1'b1;
    assign rng_datab  = '0;

endmodule

// File: tb/tb_dice_roll_arbiter.sv
// Self-checking bench for dice_roll_arbiter: directed and randomized rolls against a behavioural model.
// Build with +define+DICE_ARB_TIMEOUT_EN to exercise the WAIT-state timeout path.
`timescale 1ns/1ps
module tb_dice_roll_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 4;
    localparam int TMO = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] die_sel;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    rsp_valid;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic             busy;
    logic             rng_clk_en;
    logic             rng_start;
    logic [31:0]      rng_dataa;
    logic [31:0]      rng_datab;
    logic [31:0]      rng_result;
    logic             rng_done;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_ptr;
    int          start_count = 0;
    int          eng_delay;
    logic [31:0] eng_result;
    bit          eng_never;
    int          rsp_count [NR];

    dice_roll_arbiter #(
        .NUM_REQ        (NR),
        .DIE_W          (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .die_sel    (die_sel),
        .ack        (ack),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .rng_clk_en (rng_clk_en),
        .rng_start  (rng_start),
        .rng_dataa  (rng_dataa),
        .rng_datab  (rng_datab),
        .rng_result (rng_result),
        .rng_done   (rng_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: answers each start pulse after eng_delay cycles (0 = during the start cycle).
    initial begin
        rng_done   = 1'b0;
        rng_result = '0;
        forever begin
            @(posedge clk); #1;
            rng_done = 1'b0;
            if (rng_start === 1'b1) begin
                start_count++;
                if (!eng_never) begin
                    repeat (eng_delay) begin
                        @(posedge clk); #1;
                    end
                    rng_result = eng_result;
                    rng_done   = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] m, input int p);
        for (int k = 0; k < NR; k++) begin
            if (m[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic wait_ack(output logic [NR-1:0] seen, output int at);
        seen = '0;
        at   = cyc;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (ack != '0) begin
                seen = ack;
                at   = cyc;
                return;
            end
        end
    endtask

    task automatic wait_rsp(input int bound, output logic [NR-1:0] v, output logic [31:0] d,
                            output logic e, output int at);
        v  = '0;
        d  = '0;
        e  = 1'b0;
        at = cyc;
        for (int n = 0; n < bound; n++) begin
            @(posedge clk); #1;
            if (rsp_valid != '0) begin
                v  = rsp_valid;
                d  = rsp_data;
                e  = rsp_err;
                at = cyc;
                return;
            end
        end
    endtask

    // One complete roll: request, grant, engine exchange, response, all compared with the model.
    task automatic apply_stimulus(input logic [NR-1:0] mask, input logic [NR*DW-1:0] sel,
                                  input int delay, input logic [31:0] value, input bit drop);
        int            owner, t0, ta, tr, starts0;
        logic [DW-1:0] code;
        bit            bad;
        logic [NR-1:0] a, v;
        logic [31:0]   d;
        logic          e;
        owner      = pick(mask, exp_ptr);
        code       = sel[owner*DW +: DW];
        bad        = !(int'(code) inside {[0:6]});
        eng_delay  = delay;
        eng_result = value;
        starts0    = start_count;
        req        = mask;
        die_sel    = sel;
        t0         = cyc;
        wait_ack(a, ta);
        check_output("ack", a, 32'(NR'(1) << owner));
        check_output("ack_latency", ta - t0, 1);
        if (!bad) begin
            check_output("rng_start", rng_start, 1);
            check_output("rng_dataa", rng_dataa, 32'(code));
        end
        if (drop) req = '0;
        wait_rsp(40, v, d, e, tr);
        check_output("rsp_valid", v, 32'(NR'(1) << owner));
        check_output("rsp_data", d, bad ? 32'd0 : value);
        check_output("rsp_err", e, bad);
        check_output("rsp_latency", tr - ta, bad ? 1 : delay + 2);
        check_output("engine_starts", start_count - starts0, bad ? 0 : 1);
        for (int i = 0; i < NR; i++) if (v[i]) rsp_count[i]++;
        exp_ptr = (owner + 1) % NR;
    endtask

    initial begin
        logic [NR-1:0]    a, v;
        logic [31:0]      d;
        logic             e;
        int               ta, tr, stray;
        logic [NR*DW-1:0] sel;

        reset      = 1'b1;
        req        = '0;
        die_sel    = '0;
        eng_delay  = 0;
        eng_result = '0;
        eng_never  = 1'b0;
        exp_ptr    = 0;
        for (int i = 0; i < NR; i++) rsp_count[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_ack", ack, 0);
        check_output("reset_rsp_valid", rsp_valid, 0);
        check_output("reset_rsp_data", rsp_data, 0);
        check_output("reset_rsp_err", rsp_err, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_rng_start", rng_start, 0);
        check_output("reset_rng_dataa", rng_dataa, 0);
        check_output("rng_clk_en", rng_clk_en, 1);
        check_output("rng_datab", rng_datab, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] single D20 roll from requester 0");
        apply_stimulus(4'b0001, 16'h0005, 3, 32'd17, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_output("rsp_data_hold", rsp_data, 32'd17);
        check_output("rsp_valid_idle", rsp_valid, 0);

        $display("[TB] invalid die code from requester 2");
        apply_stimulus(4'b0100, 16'h0F00, 0, 32'hDEAD_BEEF, 1'b1);

        $display("[TB] same-cycle done from requester 3");
        apply_stimulus(4'b1000, 16'h3000, 0, $urandom, 1'b1);

        $display("[TB] randomized rolls");
        for (int r = 0; r < 30; r++) begin
            for (int s = 0; s < NR; s++) begin
                sel[s*DW +: DW] = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(7, 15))
                                                              : DW'($urandom_range(0, 6));
            end
            apply_stimulus(NR'($urandom_range(1, 15)), sel, $urandom_range(0, 4), $urandom, 1'b1);
        end

        $display("[TB] fairness with all requests held");
        for (int i = 0; i < NR; i++) rsp_count[i] = 0;
        for (int r = 0; r < 40; r++) begin
            apply_stimulus(4'b1111, 16'h3210, $urandom_range(0, 3), $urandom, 1'b0);
        end
        req = '0;
        for (int i = 0; i < NR; i++) check_output($sformatf("fair_count_%0d", i), rsp_count[i], 10);

        $display("[TB] reset during WAIT");
        apply_stimulus(4'b0010, 16'h0010, 1, $urandom, 1'b1);
        eng_delay  = 6;
        eng_result = 32'h1234;
        req        = 4'b1000;
        die_sel    = 16'h1000;
        wait_ack(a, ta);
        check_output("abort_ack", a, 4'b1000);
        req = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        exp_ptr = 0;
        stray   = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid != '0) stray++;
        end
        check_output("abort_no_rsp", stray, 0);
        check_output("abort_busy", busy, 0);
        apply_stimulus(4'b1111, 16'h3210, 1, $urandom, 1'b1);

        $display("[TB] engine never answers");
        eng_never = 1'b1;
        req       = 4'b0010;
        die_sel   = 16'h0020;
        wait_ack(a, ta);
        check_output("stall_ack", a, 4'b0010);
        req = '0;
`ifdef DICE_ARB_TIMEOUT_EN
        wait_rsp(40, v, d, e, tr);
        check_output("timeout_rsp_valid", v, 4'b0010);
        check_output("timeout_rsp_err", e, 1);
        check_output("timeout_rsp_data", d, 0);
        check_output("timeout_latency", tr - ta, TMO + 2);
        exp_ptr = 2;
`else
        stray = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (rsp_valid != '0) stray++;
        end
        check_output("stall_no_rsp", stray, 0);
        check_output("stall_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        exp_ptr = 0;
        check_output("stall_reset_busy", busy, 0);
`endif
        eng_never = 1'b0;
        apply_stimulus(4'b0101, 16'h0406, 2, $urandom, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dice_roll_arbiter.md
Name: dice_roll_arbiter

Overview:
- Shares one dice-roll custom-instruction engine (start/dataa/datab/result/done handshake, LFSR-backed) between NUM_REQ independent requesters (e.g. per-player button/UART front ends).
- Round-robin arbitration; sequences exactly one roll at a time: issue, wait for done, return result to the owning requester.
- Sits between the requester front ends and the RNG instruction engine, replacing direct Nios-driven sequencing in standalone (non-CPU) builds.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DIE_W, 4, width of die-select code
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit (used only with DICE_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester roll request; level, held until ack
- die_sel  in  NUM_REQ*DIE_W  per-requester die code, slice i = [i*DIE_W +: DIE_W]
- ack  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: result ready for that requester
- rsp_data  out  32  roll result; valid only with rsp_valid
- rsp_err  out  1  qualifies rsp_valid: invalid die code or timeout
- busy  out  1  high in any state other than IDLE
- rng_clk_en  out  1  engine clock enable; constant 1
- rng_start  out  1  engine start, 1-cycle pulse
- rng_dataa  out  32  die code, zero-extended
- rng_datab  out  32  constant 0
- rng_result  in  32  engine result
- rng_done  in  1  engine done

Behaviour:
- Reset: state IDLE, RR pointer 0, ack 0, rsp_valid 0, rsp_data 0, rsp_err 0, busy 0, rng_start 0, rng_dataa 0. Reset mid-roll aborts; no response for the aborted roll. An rng_done arriving in IDLE is ignored.
- Valid die codes (0..6): D4, D6, D8, D10, D12, D20 (code 5), D100. Codes 7..15 are invalid.
- IDLE: if any req, pick the first set bit searching from pointer upward with wrap. At that edge: latch owner and its die_sel, pulse ack[owner]. Go to ISSUE on a valid code, or to RESP with rsp_err=1 and rsp_data=0 on an invalid code (engine untouched).
- ISSUE (1 cycle): rng_start=1, rng_dataa=latched code. If rng_done is already high this cycle, capture rng_result and go to RESP; otherwise go to WAIT.
- WAIT: hold until rng_done=1, capture rng_result, go to RESP. No cycle limit unless the optional feature is enabled.
- RESP (1 cycle): rsp_valid[owner]=1, rsp_data=captured value, rsp_err as set. Pointer becomes owner+1 mod NUM_REQ. Return to IDLE.
- Minimum roll latency: req high at edge t gives ack at t+1, rng_start during cycle t+1, rsp_valid at t+3 with a same-cycle done. Next grant no earlier than the cycle after RESP.
- Requesters must hold req and die_sel until ack. Dropping req before ack withdraws the request with no side effects. req held after ack is treated as a new request.
- Outputs are registered; rsp_data holds its last value between responses.

Optional Feature:
- Macro DICE_ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If TIMEOUT_CYCLES elapse without rng_done, go to RESP with rsp_err=1 and rsp_data=0. A late rng_done is ignored.
- Undefined: no counter; WAIT waits indefinitely.

Decomposition:
- Package dice_pkg holds:
  - die-code localparams (DIE_D4=0 … DIE_D20=5, DIE_D100=6, DIE_MAX_VALID=6)
  - FSM state encoding (IDLE, ISSUE, WAIT, RESP)
  - the 32-bit result width
- Sub-module rr_arbiter (req, pointer → one-hot grant, any_req): combinational, reused by other shared resources.

Test Plan:
- Single request: req[0] with code 5, engine done 3 cycles after start returns 17 → ack[0] at t+1, one rng_start pulse with rng_dataa=5, rsp_valid[0] with rsp_data=17, rsp_err=0.
- Fairness: all four req held continuously → grants in order 0,1,2,3,0,…; over 40 rolls each requester receives exactly 10 rsp_valid pulses.
- Invalid code: req[2] with code 0xF → ack[2], rsp_valid[2] with rsp_err=1 and rsp_data=0, no rng_start.
- Reset mid-WAIT: assert reset one cycle into WAIT, then deliver rng_done → no rsp_valid, busy=0, next grant goes to requester 0.
- Same-cycle done: rng_done high during ISSUE → rsp_valid exactly 2 cycles after ack.
- With DICE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: engine never asserts done → rsp_err=1 in RESP 8 cycles after entering WAIT; otherwise the bench checks that no response is produced.
